array_pulse_sequencer: RTL
==========================

// Module: array_pulse_sequencer
// PURPOSE
//  Upstream driver of the array decoder. Takes one command per handshake and walks
//  adr_full_col over a range of column addresses. For each address it emits a
//  SETUP/PULSE/HOLD pattern on CBLEN/CBL/CSL, or a single-cycle read_out strobe.
//  Sits between the host/config interface and the decoder.
// PARAMETERS
//  Nword   3       word-address bits within one array
//  Narray  2       array-select bits (MSBs of adr_full_col)
//  N       Nword+Narray  full column-address width
//  PW      8       width of pulse-length field
// PORTS
//  clk           in   1     clock
//  rst           in   1     synchronous active-high reset
//  cmd_valid     in   1     command offered
//  cmd_ready     out  1     sequencer can accept (IDLE only)
//  cmd_op        in   2     0 INFER, 1 SET, 2 RESET, 3 READOUT
//  cmd_adr       in   N     first column address
//  cmd_len       in   N+1   number of addresses (0..2**N)
//  cmd_pulse     in   PW    PULSE-phase length in cycles (0 treated as 1)
//  abort         in   1     terminate current command
//  adr_full_col  out  N     column address to decoder
//  CBLEN         out  1     bitline enable
//  CBL           out  1     bitline drive
//  CSL           out  1     sourceline drive
//  read_out      out  1     read-out strobe; decoder deselects while high
//  busy          out  1     command in progress
//  done          out  1     one-cycle pulse at command end
//  aborted       out  1     valid with done; 1 if ended by abort
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0 except cmd_ready=1. Clears latched command.
//  Accept: cmd_valid&&cmd_ready on edge T latches op/adr/len/pulse. Later cmd_* changes are ignored.
//  FSM: IDLE -> SETUP -> PULSE -> HOLD -> (SETUP | DONE) -> IDLE. READOUT uses RDOUT instead of SETUP..HOLD.
//   SETUP  1 cycle:  CBLEN=1, CBL=0, CSL=0, adr valid.
//   PULSE  max(cmd_pulse,1) cycles, CBLEN=1, with
//          INFER: CBL=1 CSL=1
//          SET:   CBL=1 CSL=0
//          RESET: CBL=0 CSL=1
//   HOLD   1 cycle: CBLEN=1, CBL=CSL=0. Remaining count>0 -> SETUP at adr+1; else DONE.
//   RDOUT  1 cycle per address: read_out=1, CBLEN=CBL=CSL=0.
//   DONE   1 cycle: done=1, busy=0, all drives 0. Next cycle IDLE, cmd_ready=1.
//  Latency and timing:
//   - First SETUP at T+1.
//   - Per-word cost is P+2 cycles. READOUT costs 1 cycle per word.
//   - done asserts at T+1+len*(P+2) (pulse ops) or T+1+len (READOUT).
//  busy: 1 in every state except IDLE and DONE. cmd_ready = (state==IDLE).
//  Addresses: adr_full_col is registered and constant through SETUP..HOLD of a word.
//   - Increment is mod 2**N; 5'b11111+1 wraps to 0.
//   - In IDLE/DONE it holds its last value.
//  len==0: accepted, no SETUP/RDOUT, DONE at T+1 with aborted=0.
//  cmd_len > 2**N: saturated to 2**N.
//  abort:
//   - In SETUP or PULSE: next state HOLD (drives drop next cycle), then DONE with aborted=1.
//   - In HOLD or RDOUT: next state DONE with aborted=1.
//   - In IDLE or DONE: ignored. abort has priority over the word-advance decision.
//  Glitch-free: CBL/CSL never high while CBLEN=0. CBL/CSL change only on a SETUP->PULSE or PULSE->HOLD edge.
//  rst mid-command: next cycle all drives 0, IDLE, no done pulse.
// STRUCTURE
//  Package fraise_seq_pkg:
//   - op_e {OP_INFER, OP_SET, OP_RESET, OP_READOUT}
//   - state_e {IDLE, SETUP, PULSE, HOLD, RDOUT, DONE}
//   - function op_drive(op_e) -> {CBL,CSL}
//  Sub-module pulse_timer:
//   - PW-bit down-counter with load/expire, used for the PULSE phase.
//  All outputs registered; no combinational path from cmd_* to the drives.
// TESTING
//  1 SET, adr=5'd4, len=3, pulse=2:
//    - adr 4,5,6, each SETUP(1)/PULSE(2, CBL=1 CSL=0)/HOLD(1).
//    - done at T+13, aborted=0.
//  2 INFER, adr=5'd30, len=4, pulse=1:
//    - adr sequence 30,31,0,1 (wrap).
//    - CBL=CSL=1 only in PULSE cycles; done at T+13.
//  3 READOUT, adr=0, len=8:
//    - read_out=1 for 8 consecutive cycles, adr 0..7, drives 0, done at T+9.
//  4 RESET, len=2, pulse=5; abort in 3rd PULSE cycle of word 0:
//    - HOLD next cycle, then done=1 with aborted=1.
//    - CSL never reasserts; word 1 never addressed.
//  5 Edge cases:
//    - len=0 -> done at T+1, no drive activity.
//    - pulse=0 -> PULSE lasts 1 cycle.
//    - cmd_valid held high while busy -> not accepted until cmd_ready.
//  6 rst asserted during PULSE:
//    - Next cycle CBLEN=CBL=CSL=0, busy=0, cmd_ready=1, no done.
//    - A new command afterwards runs normally.

Source files
------------

// File: rtl/fraise_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fraise_seq_pkg                                                      |
// | Shared op/state encodings and drive table for the pulse sequencer.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package fraise_seq_pkg;

  typedef enum logic [1:0] {
    OP_INFER   = 2'd0,
    OP_SET     = 2'd1,
    OP_RESET   = 2'd2,
    OP_READOUT = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    RDOUT = 3'd4,
    DONE  = 3'd5
  } state_e;

  // {CBL, CSL} levels during the PULSE phase of each operation.
  function automatic logic [1:0] op_drive(input op_e op);
    case (op)
      OP_INFER: return 2'b11;
      OP_SET:   return 2'b10;
      OP_RESET: return 2'b01;
      default:  return 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/array_pulse_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | array_pulse_sequencer_if                                            |
// | Command handshake plus decoder-facing drives of the sequencer.      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface array_pulse_sequencer_if #(
  parameter int NWORD  = 3,
  parameter int NARRAY = 2,
  parameter int PW     = 8
);
  localparam int N = NWORD + NARRAY;

  logic                  cmd_valid;
  logic                  cmd_ready;
  fraise_seq_pkg::op_e   cmd_op;
  logic [N-1:0]          cmd_adr;
  logic [N:0]            cmd_len;
  logic [PW-1:0]         cmd_pulse;
  logic                  abort;
  logic [N-1:0]          adr_full_col;
  logic                  CBLEN;
  logic                  CBL;
  logic                  CSL;
  logic                  read_out;
  logic                  busy;
  logic                  done;
  logic                  aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_adr, cmd_len, cmd_pulse, abort,
    input  cmd_ready, adr_full_col, CBLEN, CBL, CSL, read_out, busy, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_adr, cmd_len, cmd_pulse, abort,
    output cmd_ready, adr_full_col, CBLEN, CBL, CSL, read_out, busy, done, aborted
  );

endinterface
`default_nettype wire

// File: rtl/pulse_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_timer                                                         |
// | Loadable down-counter timing the PULSE phase; expire marks last cyc.|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module pulse_timer #(
  parameter int PW = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          load,
  input  wire logic          dec,
  input  wire logic [PW-1:0] load_val,
  output logic               expire
);

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q <= PW'(1));

endmodule
`default_nettype wire

// File: rtl/array_pulse_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | array_pulse_sequencer                                               |
// | Walks a column range emitting SETUP/PULSE/HOLD or read-out strobes. |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module array_pulse_sequencer
  import fraise_seq_pkg::*;
#(
  parameter int NWORD  = 3,
  parameter int NARRAY = 2,
  parameter int PW     = 8
) (
  input wire logic             clk,
  input wire logic             rst,
  array_pulse_sequencer_if.slave bus
);

  localparam int         N       = NWORD + NARRAY;
  localparam logic [N:0] MAX_LEN = {1'b1, {N{1'b0}}};
  localparam logic [N:0] ONE_LEN = {{N{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [N-1:0]  adr_q, adr_d;
  logic [N:0]    rem_q, rem_d;
  logic          abort_pend_q, abort_pend_d;
  logic          cblen_q, cblen_d, cbl_q, cbl_d, csl_q, csl_d;
  logic          read_out_q, read_out_d, busy_q, busy_d;
  logic          done_q, done_d, aborted_q, aborted_d, cmd_ready_q, cmd_ready_d;

  logic          ended_by_abort;
  logic [N:0]    len_sat;
  logic          timer_load, timer_expire;
  logic [PW-1:0] timer_val;

  assign len_sat    = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;
  assign timer_load = (state_q == SETUP) && (state_d == PULSE);
  assign timer_val  = (pulse_q == '0) ? PW'(1) : pulse_q;

  pulse_timer #(.PW(PW)) u_pulse_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .dec      (state_q == PULSE),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    pulse_d        = pulse_q;
    adr_d          = adr_q;
    rem_d          = rem_q;
    abort_pend_d   = abort_pend_q;
    ended_by_abort = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d         = bus.cmd_op;
          pulse_d      = bus.cmd_pulse;
          abort_pend_d = 1'b0;
          if (len_sat == '0) begin
            state_d = DONE;
          end else begin
            adr_d   = bus.cmd_adr;
            rem_d   = len_sat - ONE_LEN;
            state_d = (bus.cmd_op == OP_READOUT) ? RDOUT : SETUP;
          end
        end
      end
      // An abort during drive phases still passes through HOLD so the
      // bitline/sourceline drop before the command is closed out.
      SETUP: begin
        if (bus.abort) begin
          state_d      = HOLD;
          abort_pend_d = 1'b1;
        end else begin
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (bus.abort) begin
          state_d      = HOLD;
          abort_pend_d = 1'b1;
        end else if (timer_expire) begin
          state_d = HOLD;
        end
      end
      HOLD, RDOUT: begin
        if (bus.abort || abort_pend_q) begin
          state_d        = DONE;
          ended_by_abort = 1'b1;
        end else if (rem_q != '0) begin
          state_d = (state_q == HOLD) ? SETUP : RDOUT;
          adr_d   = adr_q + N'(1);
          rem_d   = rem_q - ONE_LEN;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cblen_d      = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
    {cbl_d, csl_d} = (state_d == PULSE) ? op_drive(op_q) : 2'b00;
    read_out_d   = (state_d == RDOUT);
    busy_d       = (state_d != IDLE) && (state_d != DONE);
    done_d       = (state_d == DONE);
    aborted_d    = (state_d == DONE) && ended_by_abort;
    cmd_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_INFER;
      pulse_q      <= '0;
      adr_q        <= '0;
      rem_q        <= '0;
      abort_pend_q <= 1'b0;
      cblen_q      <= 1'b0;
      cbl_q        <= 1'b0;
      csl_q        <= 1'b0;
      read_out_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      pulse_q      <= pulse_d;
      adr_q        <= adr_d;
      rem_q        <= rem_d;
      abort_pend_q <= abort_pend_d;
      cblen_q      <= cblen_d;
      cbl_q        <= cbl_d;
      csl_q        <= csl_d;
      read_out_q   <= read_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.adr_full_col = adr_q;
  assign bus.CBLEN        = cblen_q;
  assign bus.CBL          = cbl_q;
  assign bus.CSL          = csl_q;
  assign bus.read_out     = read_out_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;

endmodule
`default_nettype wire
